gave_cmd_out_pio: RTL

Avalon-MM slave output port that sends words from the HPS/Nios bus to the GAVE hardware block over a 4-phase req/ack handshake. It is the bus-to-hardware counterpart of the read-only GAVE coordinate input port. Software writes a command word and the block holds it on `out_port` while it drives the handshake. Software polls status for busy, timeout and overrun, and reads a counter of completed transfers.

---
 rtl/gave_cmd_out_pio_if.sv | 23 ++
 rtl/gave_cmd_out_pio.sv | 118 +++++++++++
 2 files changed

// File: rtl/gave_cmd_out_pio_if.sv
// Avalon-MM slave bus plus GAVE req/ack handshake for the command output port.
interface gave_cmd_out_pio_if #(
    parameter int WIDTH = 16
);
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;
    logic             out_req;
    logic             in_ack;

    modport master (
        output address, chipselect, write_n, writedata, in_ack,
        input  readdata, out_port, out_req
    );

    modport slave (
        input  address, chipselect, write_n, writedata, in_ack,
        output readdata, out_port, out_req
    );
endinterface

// File: rtl/gave_cmd_out_pio.sv
// Bus-to-GAVE command output port: holds a command word and drives a
// 4-phase req/ack handshake with timeout, overrun and transfer count.
module gave_cmd_out_pio #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    gave_cmd_out_pio_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] port_q;
    logic [15:0]      tcnt;
    logic [15:0]      count;
    logic             to_flag;
    logic             ov_flag;
    logic [31:0]      rd_nxt;

    logic wr;
    logic data_wr;
    logic status_wr;
    logic busy;
    logic load;
    logic tcnt_inc;
    logic set_to;
    logic done;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign data_wr   = wr & (bus.address == 2'd0);
    assign status_wr = wr & (bus.address == 2'd1);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        tcnt_inc  = 1'b0;
        set_to    = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (data_wr) begin
                    load      = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.in_ack) begin
                    state_nxt = RELEASE;
                end else if (TO_EN && tcnt == TO_LAST) begin
                    set_to    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
            RELEASE: begin
                if (!bus.in_ack) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Readback uses pre-edge state, so a same-edge write is not yet visible.
    always_comb begin
        rd_nxt = '0;
        unique case (bus.address)
            2'd0:    rd_nxt = 32'(port_q);
            2'd1:    rd_nxt = {29'd0, ov_flag, to_flag, busy};
            2'd3:    rd_nxt = {16'd0, count};
            default: rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            port_q       <= '0;
            tcnt         <= '0;
            count        <= '0;
            to_flag      <= 1'b0;
            ov_flag      <= 1'b0;
            bus.readdata <= '0;
        end else begin
            state        <= state_nxt;
            bus.readdata <= rd_nxt;
            if (load) begin
                port_q <= bus.writedata[WIDTH-1:0];
                tcnt   <= '0;
            end else if (tcnt_inc) begin
                tcnt <= tcnt + 16'd1;
            end
            if (done) begin
                count <= count + 16'd1;
            end
            // Set wins over a coincident W1C clear.
            to_flag <= set_to |
                (to_flag & ~(status_wr & bus.writedata[1]));
            ov_flag <= (data_wr & busy) |
                (ov_flag & ~(status_wr & bus.writedata[2]));
        end
    end

    assign bus.out_port = port_q;
    assign bus.out_req  = (state == REQ);
endmodule
